// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared constants and the fetch-queue entry type for the
// instruction fetch unit and its bench.
package riscv_fetch_pkg;
   localparam int XLEN = 32;
   localparam int IMEM_AW = 29;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {instr, pc}; flush wins over push/pop, and
// storage is registered so the head never bypasses the memory read data.
module fetch_queue
   import riscv_fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t head_o,
   output logic [1:0]   occ_o
);
   fetch_entry_t r_mem [2];
   logic         r_rd;
   logic         r_wr;
   logic [1:0]   r_occ;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_occ    <= 2'd0;
      end else if (flush_i) begin
         r_rd  <= 1'b0;
         r_wr  <= 1'b0;
         r_occ <= 2'd0;
      end else begin
         if (push_i) begin
            r_mem[r_wr] <= push_data_i;
            r_wr        <= ~r_wr;
         end
         if (pop_i) r_rd <= ~r_rd;
         r_occ <= r_occ + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_o = r_mem[r_rd];
   assign occ_o  = r_occ;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, tracks the 1-cycle memory read latency
// and feeds decode from a 2-entry queue; redirect flushes queued and in-flight words.
module instr_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   output logic [IMEM_AW-1:0]  mem_addr_o,
   input  logic [XLEN-1:0]     mem_instr_i,
   output logic [XLEN-1:0]     instr_o,
   output logic [XLEN-1:0]     pc_o,
   output logic                valid_o,
   input  logic                ready_i,
   input  logic                redirect_i,
   input  logic [XLEN-1:0]     redirect_pc_i
);
   localparam logic [1:0] DEPTH = BUF_DEPTH[1:0];

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_inflight_pc;
   logic            r_inflight;
   logic            r_kill;
   logic [1:0]      w_occ;
   logic [1:0]      w_cnt;
   logic            w_pop;
   logic            w_push;
   logic            w_issue;
   logic            w_unused;
   fetch_entry_t    w_head;

   // occupancy plus the word still in flight must never exceed the queue depth
   assign w_cnt    = w_occ + {1'b0, r_inflight};
   assign valid_o  = (w_occ != 2'd0);
   assign w_pop    = valid_o & ready_i;
   assign w_issue  = !redirect_i && ((w_cnt < DEPTH) || (w_cnt == DEPTH && w_pop));
   assign w_push   = r_inflight & ~r_kill & ~redirect_i;
   assign w_unused = &{1'b0, redirect_pc_i[1:0]};

   assign mem_addr_o = r_pc[IMEM_AW+1:2];
   assign instr_o    = w_head.instr;
   assign pc_o       = w_head.pc;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pc          <= RESET_PC;
         r_inflight_pc <= '0;
         r_inflight    <= 1'b0;
         r_kill        <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_kill     <= redirect_i & r_inflight;
         if (redirect_i) begin
            r_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
         end else if (w_issue) begin
            r_pc          <= r_pc + PC_INC;
            r_inflight_pc <= r_pc;
         end
      end
   end

   fetch_queue u_queue (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (w_push),
      .push_data_i ('{instr: mem_instr_i, pc: r_inflight_pc}),
      .pop_i       (w_pop),
      .flush_i     (redirect_i),
      .head_o      (w_head),
      .occ_o       (w_occ)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a 1-cycle-latency ROM model;
// outputs are sampled on the falling edge.
module tb_instr_fetch_unit;
   import riscv_fetch_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        ready_i = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic [31:0] mem_instr_i = '0;
   logic [28:0] mem_addr_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic [31:0] rom [64];

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   instr_fetch_unit dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .mem_addr_o    (mem_addr_o),
      .mem_instr_i   (mem_instr_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i)
   );

   always #5 clk_i = ~clk_i;

   // the top word of the address space holds a distinct marker instruction
   always @(posedge clk_i)
      mem_instr_i <= (mem_addr_o == 29'h1FFF_FFFF) ? 32'h0010_0073 : rom[mem_addr_o[5:0]];

   always @(negedge clk_i) begin
      if (rst_ni) begin
         n_total++;
         assert (!(dut.w_push && dut.w_occ == 2'd2)) n_pass++;
         else begin
            n_fail++;
            $error("FAIL push_full: observed push into occ=%0d required no push", dut.w_occ);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic out(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p);
      chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
      if (v) begin
         chk({tag, ".instr"}, instr_o, i);
         chk({tag, ".pc"}, pc_o, p);
      end
   endtask

   task automatic addr(input string tag, input logic [28:0] a);
      chk({tag, ".addr"}, {3'd0, mem_addr_o}, {3'd0, a});
   endtask

   initial begin
      foreach (rom[i]) rom[i] = NOP;
      rom[0]  = 32'h8000_0537;
      rom[1]  = 32'h1005_0513;
      rom[2]  = 32'h0000_0293;
      rom[3]  = 32'h0055_0023;
      rom[14] = 32'hfe05_94e3;
      rom[15] = 32'h0000_006f;

      // reset state and gap-free stream
      tick(); tick();
      chk("rst.valid", {31'd0, valid_o}, 32'd0);
      chk("rst.instr", instr_o, 32'd0);
      chk("rst.pc", pc_o, 32'd0);
      addr("rst", 29'd0);
      rst_ni = 1'b1;
      tick(); addr("s1.t1", 29'd1); out("s1.t1", 1'b0, 0, 0);
      tick(); addr("s1.t2", 29'd2); out("s1.t2", 1'b1, 32'h8000_0537, 32'h0);
      tick(); addr("s1.t3", 29'd3); out("s1.t3", 1'b1, 32'h1005_0513, 32'h4);
      tick(); out("s1.t4", 1'b1, 32'h0000_0293, 32'h8);
      tick(); out("s1.t5", 1'b1, 32'h0055_0023, 32'hC);
      tick(); out("s1.t6", 1'b1, NOP, 32'h10);

      // redirect with a word in flight, a push and a pop in the same cycle
      redirect_i = 1'b1; redirect_pc_i = 32'h38;
      tick(); redirect_i = 1'b0;
      out("s3.r1", 1'b0, 0, 0); addr("s3.r1", 29'h0E);
      tick(); out("s3.r2", 1'b0, 0, 0); addr("s3.r2", 29'h0F);
      tick(); out("s3.r3", 1'b1, 32'hfe05_94e3, 32'h38);
      tick(); out("s3.r4", 1'b1, 32'h0000_006f, 32'h3C);

      // redirect back to 0 while ready and push are active
      redirect_i = 1'b1; redirect_pc_i = 32'h0;
      tick(); redirect_i = 1'b0;
      out("s4.r1", 1'b0, 0, 0); addr("s4.r1", 29'h0);
      tick(); out("s4.r2", 1'b0, 0, 0);
      tick(); out("s4.r3", 1'b1, 32'h8000_0537, 32'h0);

      // back-to-back redirects, last wins; target low bits ignored; address wraps
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      tick(); out("s5.q0", 1'b0, 0, 0); addr("s5.q0", 29'h10);
      redirect_pc_i = 32'hFFFF_FFFE;
      tick(); redirect_i = 1'b0;
      out("s5.q1", 1'b0, 0, 0); addr("s5.q1", 29'h1FFF_FFFF);
      tick(); out("s5.q2", 1'b0, 0, 0); addr("s5.q2", 29'h0);
      tick(); out("s5.q3", 1'b1, 32'h0010_0073, 32'hFFFF_FFFC);
      tick(); out("s5.q4", 1'b1, 32'h8000_0537, 32'h0);

      // fill the queue, then reset mid-stream
      ready_i = 1'b0;
      tick(); out("s6.full", 1'b1, 32'h8000_0537, 32'h0); addr("s6.full", 29'd2);
      rst_ni = 1'b0;
      tick();
      chk("s6.rst.valid", {31'd0, valid_o}, 32'd0);
      chk("s6.rst.instr", instr_o, 32'd0);
      chk("s6.rst.pc", pc_o, 32'd0);
      addr("s6.rst", 29'd0);
      rst_ni = 1'b1; ready_i = 1'b1;
      tick(); addr("s6.t1", 29'd1); out("s6.t1", 1'b0, 0, 0);
      tick(); out("s6.t2", 1'b1, 32'h8000_0537, 32'h0);

      // stall five cycles: head held, issue stops at occ=2
      ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(); out("s2.hold", 1'b1, 32'h8000_0537, 32'h0); addr("s2.hold", 29'd2);
      end
      tick(); out("s2.rel", 1'b1, 32'h8000_0537, 32'h0);
      ready_i = 1'b1;
      tick(); out("s2.c1", 1'b1, 32'h1005_0513, 32'h4);
      tick(); out("s2.c2", 1'b1, 32'h0000_0293, 32'h8);
      tick(); out("s2.c3", 1'b1, 32'h0055_0023, 32'hC);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
